// File: rtl/dnn_pkg.sv
// Shared widths and types for the DNN accuracy monitor slice.
package dnn_pkg;

  localparam int EPOCH_W = 16;

  // Width of a count that must be able to hold 0..window inclusive.
  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction

  // Index width for 0..tc-1; never below one bit.
  function automatic int tc_w(input int tc);
    return (tc > 1) ? $clog2(tc) : 1;
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic correct;
  } case_res_t;

endpackage

// File: rtl/correct_window.sv
// Circular buffer of the last WINDOW case results with a running count of ones.
module correct_window
  import dnn_pkg::*;
#(
  parameter int WINDOW = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     bit_in,
  output logic [win_w(WINDOW)-1:0] count
);

  localparam int CW = win_w(WINDOW);
  localparam int PW = ptr_w(WINDOW);

  logic [WINDOW-1:0] r_buf;
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_count;
  logic              w_evict;

  assign w_evict = r_buf[r_ptr];

  // Slots not yet written hold 0, so the count covers min(cases, WINDOW).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_buf   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_buf[r_ptr] <= bit_in;
      r_count      <= r_count + CW'(bit_in) - CW'(w_evict);
      r_ptr        <= (r_ptr == PW'(WINDOW - 1)) ? '0 : r_ptr + PW'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dnn_accuracy_monitor.sv
// Scores streamed DNN output beats per training case and tracks totals,
// recent-window accuracy and epoch position.
module dnn_accuracy_monitor
  import dnn_pkg::*;
#(
  parameter int N_OUT   = 16,
  parameter int N_VALID = 10,
  parameter int P       = 1,
  parameter int WINDOW  = 100,
  parameter int TC      = 50000,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     out_valid,
  input  logic [P-1:0]             a_out,
  input  logic [P-1:0]             y_out,
  output logic                     case_valid,
  output logic                     case_correct,
  output logic [CNT_W-1:0]         num_train,
  output logic [CNT_W-1:0]         total_error,
  output logic [win_w(WINDOW)-1:0] recent_correct,
  output logic [tc_w(TC)-1:0]      sel_tc,
  output logic [EPOCH_W-1:0]       epoch,
  output logic                     epoch_done
);

  localparam int BEATS = N_OUT / P;
  localparam int BW    = ptr_w(BEATS);
  localparam int TW    = tc_w(TC);

  logic [BW-1:0]      r_beat;
  logic               r_mis;
  logic               r_case_valid;
  logic               r_case_correct;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_err;
  logic [TW-1:0]      r_sel;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_epoch_done;

  logic [P-1:0] w_lane_mis;
  logic         w_beat_mis;
  logic         w_wrap;
  case_res_t    w_res;

  // Padding neurons (index >= N_VALID) never count as mismatches.
  for (genvar g = 0; g < P; g++) begin : g_lane
    assign w_lane_mis[g] = (a_out[g] != y_out[g]) &&
                           ((int'(r_beat) * P + g) < N_VALID);
  end

  assign w_beat_mis    = |w_lane_mis;
  assign w_res.valid   = out_valid && (r_beat == BW'(BEATS - 1));
  assign w_res.correct = !(r_mis || w_beat_mis);
  assign w_wrap        = (r_sel == TW'(TC - 1));

  // Clear takes priority over a coincident beat, dropping any partial case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat         <= '0;
      r_mis          <= 1'b0;
      r_case_valid   <= 1'b0;
      r_case_correct <= 1'b0;
      r_num          <= '0;
      r_err          <= '0;
      r_sel          <= '0;
      r_epoch        <= '0;
      r_epoch_done   <= 1'b0;
    end else if (clear) begin
      r_beat         <= '0;
      r_mis          <= 1'b0;
      r_case_valid   <= 1'b0;
      r_case_correct <= 1'b0;
      r_num          <= '0;
      r_err          <= '0;
      r_sel          <= '0;
      r_epoch        <= '0;
      r_epoch_done   <= 1'b0;
    end else begin
      r_case_valid <= w_res.valid;
      r_epoch_done <= w_res.valid && w_wrap;
      if (out_valid) begin
        r_beat <= w_res.valid ? '0 : r_beat + BW'(1);
        r_mis  <= w_res.valid ? 1'b0 : (r_mis || w_beat_mis);
      end
      if (w_res.valid) begin
        r_case_correct <= w_res.correct;
        if (r_num != '1)
          r_num <= r_num + CNT_W'(1);
        if (!w_res.correct && (r_err != '1))
          r_err <= r_err + CNT_W'(1);
        if (w_wrap) begin
          r_sel <= '0;
          if (r_epoch != '1)
            r_epoch <= r_epoch + EPOCH_W'(1);
        end else begin
          r_sel <= r_sel + TW'(1);
        end
      end
    end
  end

  correct_window #(
    .WINDOW (WINDOW)
  ) u_window (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .push   (w_res.valid),
    .bit_in (w_res.correct),
    .count  (recent_correct)
  );

  assign case_valid   = r_case_valid;
  assign case_correct = r_case_correct;
  assign num_train    = r_num;
  assign total_error  = r_err;
  assign sel_tc       = r_sel;
  assign epoch        = r_epoch;
  assign epoch_done   = r_epoch_done;

endmodule

// File: tb/tb_dnn_accuracy_monitor.sv
// Bench for dnn_accuracy_monitor: P=1 instance for scoring/window/epoch, P=4 instance for gaps, clear and saturation.
module tb_dnn_accuracy_monitor;

  localparam int NV  = 10;
  localparam int WIN = 4;
  localparam int TCN = 3;

  logic        clk = 1'b0;
  logic        reset, clear, ov, a1, y1;
  logic        cv, cc, ed;
  logic [31:0] nt, te;
  logic [2:0]  rc;
  logic [1:0]  st;
  logic [15:0] ep;

  logic        clear4, ov4;
  logic [3:0]  a4, y4;
  logic        cv4, cc4, ed4;
  logic [3:0]  nt4, te4;
  logic [2:0]  rc4;
  logic [1:0]  st4;
  logic [15:0] ep4;

  int total = 0;
  int bad   = 0;
  int cnt4  = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (cv4 === 1'b1) cnt4++;

  dnn_accuracy_monitor #(.N_OUT(16), .N_VALID(NV), .P(1), .WINDOW(WIN), .TC(TCN), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .out_valid(ov), .a_out(a1), .y_out(y1),
    .case_valid(cv), .case_correct(cc), .num_train(nt), .total_error(te),
    .recent_correct(rc), .sel_tc(st), .epoch(ep), .epoch_done(ed));

  dnn_accuracy_monitor #(.N_OUT(16), .N_VALID(NV), .P(4), .WINDOW(WIN), .TC(TCN), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .clear(clear4), .out_valid(ov4), .a_out(a4), .y_out(y4),
    .case_valid(cv4), .case_correct(cc4), .num_train(nt4), .total_error(te4),
    .recent_correct(rc4), .sel_tc(st4), .epoch(ep4), .epoch_done(ed4));

  // Reference model: whole-case scoring and history of results.
  int hist[$];
  int m_num, m_err, m_sel, m_ep;
  bit m_ok, m_ed;

  function automatic void model_clear();
    hist.delete();
    m_num = 0; m_err = 0; m_sel = 0; m_ep = 0; m_ok = 0; m_ed = 0;
  endfunction

  function automatic void model_case(input bit [15:0] a, input bit [15:0] y);
    m_ok = 1;
    for (int i = 0; i < NV; i++) if (a[i] != y[i]) m_ok = 0;
    hist.push_back(int'(m_ok));
    m_num++;
    if (!m_ok) m_err++;
    m_ed  = (m_sel == TCN - 1);
    m_sel = (m_sel + 1) % TCN;
    if (m_ed) m_ep++;
  endfunction

  function automatic int recent();
    int s = 0;
    int n = (hist.size() < WIN) ? hist.size() : WIN;
    for (int i = hist.size() - n; i < hist.size(); i++) s += hist[i];
    return s;
  endfunction

  task automatic feed_case(input bit [15:0] a, input bit [15:0] y, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); ov = 1'b1; a1 = a[i]; y1 = y[i];
      if (gaps && i < 15) repeat ($urandom_range(0, 2)) begin @(negedge clk); ov = 1'b0; end
    end
    @(negedge clk); ov = 1'b0;
  endtask

  task automatic feed4(input bit [15:0] a, input bit [15:0] y, input bit alt);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); ov4 = 1'b1; a4 = a[b*4 +: 4]; y4 = y[b*4 +: 4];
      if (alt) begin @(negedge clk); ov4 = 1'b0; end
    end
    @(negedge clk); ov4 = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1; ov = 1'b0;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({cv, cc, ed} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {cv, cc, ed}); end
    total++; if (nt !== 32'd0 || te !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", nt, te); end
    total++; if (rc !== 3'd0 || st !== 2'd0 || ep !== 16'd0) begin bad++; $display("FAIL reset_misc got rc=%0d st=%0d ep=%0d exp=0", rc, st, ep); end
    total++; if ({cv4, cc4, ed4, nt4, te4, rc4, st4} !== '0 || ep4 !== 16'd0) begin bad++; $display("FAIL reset_p4 got nonzero outputs"); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    bit [15:0] a = 16'($urandom);
    feed_case(a, a, 1'b0); model_case(a, a);
    total++; if (cv !== 1'b1) begin bad++; $display("FAIL basic_cv got=%b exp=1", cv); end
    total++; if (cc !== 1'b1) begin bad++; $display("FAIL basic_cc got=%b exp=1", cc); end
    total++; if (nt !== 32'd1 || te !== 32'd0) begin bad++; $display("FAIL basic_cnt got=%0d/%0d exp=1/0", nt, te); end
    total++; if (rc !== 3'd1) begin bad++; $display("FAIL basic_rc got=%0d exp=1", rc); end
    @(negedge clk);
    total++; if (cv !== 1'b0 || cc !== 1'b1) begin bad++; $display("FAIL basic_hold got cv=%b cc=%b exp cv=0 cc=1", cv, cc); end
  endtask

  task automatic test_ignored();
    bit [15:0] a = 16'($urandom);
    feed_case(a, a ^ 16'h1000, 1'b0); model_case(a, a ^ 16'h1000);
    total++; if (cc !== 1'b1 || cv !== 1'b1) begin bad++; $display("FAIL ign12 got cc=%b cv=%b exp 1/1", cc, cv); end
    feed_case(a, a ^ 16'h0200, 1'b0); model_case(a, a ^ 16'h0200);
    total++; if (cc !== 1'b0) begin bad++; $display("FAIL mis9_cc got=%b exp=0", cc); end
    total++; if (te !== 32'd1 || nt !== 32'd3) begin bad++; $display("FAIL mis9_cnt got=%0d/%0d exp=1/3", te, nt); end
  endtask

  task automatic test_window();
    bit pat[6]      = '{1, 1, 0, 1, 0, 0};
    int exp_rc[6]   = '{1, 2, 2, 3, 2, 1};
    do_clear();
    for (int k = 0; k < 6; k++) begin
      bit [15:0] a = 16'($urandom);
      bit [15:0] y = pat[k] ? a : a ^ (16'd1 << $urandom_range(0, NV - 1));
      feed_case(a, y, 1'b0); model_case(a, y);
      total++; if (int'(rc) != exp_rc[k] || int'(rc) != recent()) begin bad++; $display("FAIL window_%0d got=%0d exp=%0d", k, rc, exp_rc[k]); end
      total++; if (cc !== pat[k]) begin bad++; $display("FAIL window_cc_%0d got=%b exp=%b", k, cc, pat[k]); end
    end
  endtask

  task automatic test_epoch();
    int exp_st[7] = '{1, 2, 0, 1, 2, 0, 1};
    bit exp_ed[7] = '{0, 0, 1, 0, 0, 1, 0};
    do_clear();
    for (int k = 0; k < 7; k++) begin
      bit [15:0] a = 16'($urandom);
      feed_case(a, a, 1'b0); model_case(a, a);
      total++; if (int'(st) != exp_st[k] || ed !== exp_ed[k]) begin bad++; $display("FAIL epoch_%0d got st=%0d ed=%b exp st=%0d ed=%b", k, st, ed, exp_st[k], exp_ed[k]); end
    end
    total++; if (ep !== 16'd2 || int'(ep) != m_ep) begin bad++; $display("FAIL epoch_count got=%0d exp=2", ep); end
  endtask

  task automatic test_clear_mid();
    bit [15:0] a = 16'($urandom);
    do_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ov = 1'b1; a1 = 1'b1; y1 = 1'b0; clear = (i == 5);
    end
    @(negedge clk); clear = 1'b0; ov = 1'b0;
    total++; if (nt !== 32'd0 || cv !== 1'b0) begin bad++; $display("FAIL clrmid_state got nt=%0d cv=%b exp 0/0", nt, cv); end
    feed_case(a, a, 1'b0); model_case(a, a);
    total++; if (cv !== 1'b1 || cc !== 1'b1 || nt !== 32'd1 || te !== 32'd0) begin bad++; $display("FAIL clrmid_case got cv=%b cc=%b nt=%0d te=%0d exp 1/1/1/0", cv, cc, nt, te); end
  endtask

  task automatic test_random();
    do_clear();
    for (int k = 0; k < 20; k++) begin
      bit [15:0] a = 16'($urandom);
      bit [15:0] y;
      case ($urandom_range(0, 2))
        0: y = a;
        1: y = a ^ (16'd1 << $urandom_range(0, 15));
        default: y = 16'($urandom);
      endcase
      feed_case(a, y, 1'b1); model_case(a, y);
      total++;
      if (cv !== 1'b1 || cc !== m_ok || int'(nt) != m_num || int'(te) != m_err ||
          int'(rc) != recent() || int'(st) != m_sel || int'(ep) != m_ep || ed !== m_ed) begin
        bad++;
        $display("FAIL random_%0d got cv=%b cc=%b nt=%0d te=%0d rc=%0d st=%0d ep=%0d ed=%b exp cc=%b nt=%0d te=%0d rc=%0d st=%0d ep=%0d ed=%b",
                 k, cv, cc, nt, te, rc, st, ep, ed, m_ok, m_num, m_err, recent(), m_sel, m_ep, m_ed);
      end
    end
  endtask

  task automatic test_reset_midcase();
    bit [15:0] a = 16'($urandom);
    for (int i = 0; i < 8; i++) begin @(negedge clk); ov = 1'b1; a1 = 1'b1; y1 = 1'b0; end
    @(negedge clk); ov = 1'b0; reset = 1'b1;
    #2;
    total++; if (nt !== 32'd0 || rc !== 3'd0 || st !== 2'd0 || cc !== 1'b0) begin bad++; $display("FAIL rstmid_zero got nt=%0d rc=%0d st=%0d cc=%b exp 0", nt, rc, st, cc); end
    @(negedge clk); reset = 1'b0;
    model_clear();
    feed_case(a, a, 1'b0); model_case(a, a);
    total++; if (nt !== 32'd1 || cc !== 1'b1 || te !== 32'd0 || rc !== 3'd1) begin bad++; $display("FAIL rstmid_case got nt=%0d cc=%b te=%0d rc=%0d exp 1/1/0/1", nt, cc, te, rc); end
  endtask

  task automatic test_p4_gaps();
    int c0;
    bit [15:0] a = 16'($urandom);
    @(negedge clk); clear4 = 1'b1; @(negedge clk); clear4 = 1'b0;
    c0 = cnt4;
    feed4(a, a, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (cnt4 - c0 != 1) begin bad++; $display("FAIL p4_pulses got=%0d exp=1", cnt4 - c0); end
    total++; if (cc4 !== 1'b1 || nt4 !== 4'd1) begin bad++; $display("FAIL p4_case got cc=%b nt=%0d exp 1/1", cc4, nt4); end
    feed4(a, a ^ 16'h0C00, 1'b0);
    total++; if (cc4 !== 1'b1 || cv4 !== 1'b1) begin bad++; $display("FAIL p4_ign got cc=%b cv=%b exp 1/1", cc4, cv4); end
    feed4(a, a ^ 16'h0200, 1'b1);
    total++; if (cc4 !== 1'b0 || te4 !== 4'd1 || nt4 !== 4'd3) begin bad++; $display("FAIL p4_mis9 got cc=%b te=%0d nt=%0d exp 0/1/3", cc4, te4, nt4); end
  endtask

  task automatic test_p4_clear();
    int c0 = cnt4;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); ov4 = 1'b1; a4 = 4'hF; y4 = 4'h0; clear4 = (b == 2);
    end
    @(negedge clk); ov4 = 1'b0; clear4 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cnt4 != c0) begin bad++; $display("FAIL p4clr_pulse got=%0d exp=0", cnt4 - c0); end
    total++; if ({cc4, ed4, nt4, te4, rc4, st4} !== '0 || ep4 !== 16'd0) begin bad++; $display("FAIL p4clr_zero got cc=%b nt=%0d te=%0d rc=%0d st=%0d exp 0", cc4, nt4, te4, rc4, st4); end
    for (int b = 0; b < 2; b++) begin @(negedge clk); ov4 = 1'b1; a4 = 4'h0; y4 = 4'h0; end
    @(negedge clk); ov4 = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cnt4 != c0 || nt4 !== 4'd0) begin bad++; $display("FAIL p4clr_partial got pulses=%0d nt=%0d exp 0/0", cnt4 - c0, nt4); end
  endtask

  task automatic test_p4_saturation();
    @(negedge clk); clear4 = 1'b1; @(negedge clk); clear4 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      bit [15:0] a = 16'($urandom);
      feed4(a, a ^ 16'h0001, 1'b0);
    end
    total++; if (nt4 !== 4'd15 || te4 !== 4'd15) begin bad++; $display("FAIL p4_sat got nt=%0d te=%0d exp 15/15", nt4, te4); end
    total++; if (rc4 !== 3'd0 || st4 !== 2'(17 % TCN) || ep4 !== 16'(17 / TCN)) begin bad++; $display("FAIL p4_sat_misc got rc=%0d st=%0d ep=%0d exp 0/%0d/%0d", rc4, st4, ep4, 17 % TCN, 17 / TCN); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; ov = 1'b0; a1 = 1'b0; y1 = 1'b0;
    clear4 = 1'b0; ov4 = 1'b0; a4 = '0; y4 = '0;
    test_reset();
    test_basic();
    test_ignored();
    test_window();
    test_epoch();
    test_clear_mid();
    test_random();
    test_reset_midcase();
    test_p4_gaps();
    test_p4_clear();
    test_p4_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
